// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter:
//   - FSM state encoding (IDLE / START / WAIT)
//   - default frame timeout in clk cycles
//   - byte width and maximum supported requester count
//   - onehot_to_idx helper used to turn a one-hot owner into an index
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  localparam int DATA_W          = 8;
  localparam int MAX_REQ         = 8;
  // One 9600-baud frame at 50 MHz is ~52k cycles; this leaves ample margin.
  localparam int DEFAULT_TIMEOUT = 100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Encodes a one-hot vector (up to MAX_REQ bits) as a binary index.
  // OR-ing the indices of set bits is exact for one-hot inputs and keeps
  // the logic a plain OR tree.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker.
//   req        in  N_REQ  level requests
//   last_owner in  LW     index of the most recently served requester
//   winner     out N_REQ  one-hot winner (all zero when req == 0)
// The search starts at last_owner+1 and wraps modulo N_REQ.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int LW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last_owner,
  output logic [N_REQ-1:0] winner
);

  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] masked_req;
  logic [N_REQ-1:0] pick;

  // upper_mask selects requesters strictly above last_owner; those get
  // first look before wrapping around to the full request vector.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    localparam logic [LW-1:0] POS = LW'(gi);
    assign upper_mask[gi] = (POS > last_owner);
  end

  assign masked_req = req & upper_mask;
  assign pick       = (|masked_req) ? masked_req : req;
  // Isolate the lowest set bit: x & -x.
  assign winner     = pick & (~pick + N_REQ'(1));

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART byte transmitter among N_REQ requesters with round-robin
// fairness and a per-byte completion timeout.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous active-high reset
//   enable       in   1        gates new grants only; in-flight byte completes
//   req          in   N_REQ    per-requester level request
//   req_data     in   N_REQ*8  byte of requester i on [8i+7:8i]
//   gnt          out  N_REQ    one-hot pulse: byte accepted
//   done         out  N_REQ    one-hot pulse: byte fully transmitted
//   byte_en      out  1        start pulse to the byte transmitter
//   data_byte    out  8        byte presented to the transmitter
//   tx_done      in   1        completion pulse from the transmitter
//   busy         out  1        high whenever the FSM is not IDLE
//   timeout_err  out  1        pulse when the transmitter failed to finish
//
// All outputs are registered; gnt/byte_en appear the cycle after START is
// entered, i.e. two cycles after a request is seen in IDLE.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    byte_en,
  output logic [DATA_W-1:0]       data_byte,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int LW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q;
  logic [N_REQ-1:0]    owner_oh_q;
  logic [LW-1:0]       last_owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    done_q;
  logic                byte_en_q;
  logic [DATA_W-1:0]   data_byte_q;
  logic                busy_q;
  logic                timeout_err_q;

  logic [N_REQ-1:0]    winner;
  logic [LW-1:0]       owner_idx;
  logic [DATA_W-1:0]   sel_chain [N_REQ+1];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .LW    (LW)
  ) u_rr_arbiter (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  // One-hot mux of the winner's byte, built as an OR chain.
  assign sel_chain[0] = '0;
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
    assign sel_chain[gi+1] = sel_chain[gi]
                           | ({DATA_W{winner[gi]}} & req_data[DATA_W*gi +: DATA_W]);
  end

  assign owner_idx = LW'(onehot_to_idx(MAX_REQ'(owner_oh_q)));

  // Saturating increment; in normal operation the timeout compare returns
  // to IDLE long before saturation, this only guards against wrap.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_oh_q    <= '0;
      last_owner_q  <= LW'(N_REQ - 1);
      cnt_q         <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      byte_en_q     <= 1'b0;
      data_byte_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      gnt_q         <= '0;
      done_q        <= '0;
      byte_en_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && (|req)) begin
            owner_oh_q  <= winner;
            data_byte_q <= sel_chain[N_REQ];
            state_q     <= ST_START;
            busy_q      <= 1'b1;
          end
        end
        ST_START: begin
          gnt_q     <= owner_oh_q;
          byte_en_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          // tx_done takes priority over a coincident timeout.
          if (tx_done) begin
            done_q       <= owner_oh_q;
            last_owner_q <= owner_idx;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            timeout_err_q <= 1'b1;
            last_owner_q  <= owner_idx;
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign byte_en     = byte_en_q;
  assign data_byte   = data_byte_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        byte_en;
  logic [7:0]  data_byte;
  logic        tx_done;
  logic        busy;
  logic        timeout_err;

  int checks;
  int errors;

  uart_tx_arbiter #(
    .N_REQ   (4),
    .TIMEOUT (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .byte_en     (byte_en),
    .data_byte   (data_byte),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until byte_en is seen or the cycle budget runs out.
  task automatic wait_byte_en(input int max_cycles, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max_cycles && !ok) begin
      tick();
      n++;
      if (byte_en === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({gnt, done, byte_en, data_byte, busy, timeout_err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b done=%b byte_en=%b data=%h busy=%b tmo=%b, want all 0",
               gnt, done, byte_en, data_byte, busy, timeout_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b gnt=%b, want 0 0", busy, gnt);
    end
  endtask

  task automatic test_single();
    bit early_done;
    req      = 4'b0001;
    req_data = 32'h0000_00A5;
    tick();
    checks++;
    if (gnt !== 4'b0 || byte_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start: got gnt=%b byte_en=%b busy=%b, want 0000 0 1", gnt, byte_en, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || byte_en !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt: got gnt=%b byte_en=%b, want 0001 1", gnt, byte_en);
    end
    checks++;
    if (data_byte !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h, want a5", data_byte);
    end
    req        = 4'b0000;
    early_done = 1'b0;
    repeat (19) begin
      tick();
      if (done !== 4'b0 || gnt !== 4'b0) early_done = 1'b1;
    end
    checks++;
    if (early_done) begin
      errors++;
      $display("FAIL single_quiet: got stray done/gnt during wait, want none");
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0001 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%b tmo=%b, want 0001 0", done, timeout_err);
    end
    tick();
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || data_byte !== 8'hA5) begin
      errors++;
      $display("FAIL single_after: got done=%b busy=%b data=%h, want 0000 0 a5", done, busy, data_byte);
    end
    $display("txn single: requester 0 byte a5 done");
  endtask

  task automatic test_round_robin();
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    int n;
    bit ok;
    logic [31:0] d;
    logic [7:0]  exp_byte;
    logic [3:0]  exp_oh;
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    req      = 4'b1111;
    req_data = 32'hD4C3B2A1;
    d        = req_data;
    for (int g = 0; g < 5; g++) begin
      exp_oh   = 4'(1 << exp_idx[g]);
      exp_byte = d[8*exp_idx[g] +: 8];
      wait_byte_en(6, n, ok);
      checks++;
      if (!ok || n != 2) begin
        errors++;
        $display("FAIL rr_spacing[%0d]: got byte_en after %0d cycles (seen=%0d), want 2", g, n, ok);
      end
      checks++;
      if (gnt !== exp_oh || data_byte !== exp_byte) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got gnt=%b data=%h, want gnt=%b data=%h",
                 g, gnt, data_byte, exp_oh, exp_byte);
      end
      repeat (3) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (g == 4) req = 4'b0000;
      checks++;
      if (done !== exp_oh) begin
        errors++;
        $display("FAIL rr_done[%0d]: got %b, want %b", g, done, exp_oh);
      end
      $display("txn rr[%0d]: gnt=%b data=%h done=%b", g, gnt, data_byte, done);
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    bit seen_done;
    req      = 4'b0010;
    req_data = 32'h0000_5A00;
    wait_byte_en(6, n, ok);
    checks++;
    if (!ok || gnt !== 4'b0010 || data_byte !== 8'h5A) begin
      errors++;
      $display("FAIL tmo_grant: got seen=%0d gnt=%b data=%h, want 1 0010 5a", ok, gnt, data_byte);
    end
    req       = 4'b0000;
    n         = 0;
    seen_done = 1'b0;
    while (n < 60 && timeout_err !== 1'b1) begin
      tick();
      n++;
      if (done !== 4'b0) seen_done = 1'b1;
    end
    checks++;
    if (timeout_err !== 1'b1 || n != 50) begin
      errors++;
      $display("FAIL tmo_latency: got timeout_err=%b after %0d cycles, want 1 after 50", timeout_err, n);
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL tmo_no_done: got a done pulse, want none");
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: got tmo=%b busy=%b, want 0 0", timeout_err, busy);
    end
    $display("txn timeout: requester 1 timed out after %0d cycles", n);
  endtask

  task automatic test_timeout_race();
    int n;
    bit ok;
    bit stray;
    req      = 4'b0001;
    req_data = 32'h0000_0077;
    wait_byte_en(6, n, ok);
    checks++;
    if (!ok || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL race_grant: got seen=%0d gnt=%b, want 1 0001", ok, gnt);
    end
    req   = 4'b0000;
    stray = 1'b0;
    repeat (49) begin
      tick();
      if (timeout_err !== 1'b0 || done !== 4'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL race_early: got done/timeout before last cycle, want none");
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0001 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL race_done: got done=%b tmo=%b, want 0001 0", done, timeout_err);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL race_after: got tmo=%b busy=%b, want 0 0", timeout_err, busy);
    end
    $display("txn race: requester 0 done on the final timeout cycle");
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit ok;
    bit stray;
    req      = 4'b0100;
    req_data = 32'h0033_0000;
    wait_byte_en(6, n, ok);
    req = 4'b0000;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, byte_en, data_byte, busy, timeout_err} !== 19'd0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got gnt=%b done=%b byte_en=%b data=%h busy=%b tmo=%b, want all 0",
               gnt, done, byte_en, data_byte, busy, timeout_err);
    end
    tick();
    rst      = 1'b0;
    req      = 4'b1001;
    req_data = 32'h9900_0011;
    stray    = 1'b0;
    n        = 0;
    ok       = 1'b0;
    while (n < 6 && !ok) begin
      tick();
      n++;
      if (done !== 4'b0 || timeout_err !== 1'b0) stray = 1'b1;
      if (byte_en === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || gnt !== 4'b0001 || data_byte !== 8'h11) begin
      errors++;
      $display("FAIL rst_priority: got seen=%0d gnt=%b data=%h, want 1 0001 11", ok, gnt, data_byte);
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rst_no_pulse: got done/timeout for interrupted byte, want none");
    end
    req = 4'b0000;
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL rst_done: got %b, want 0001", done);
    end
    $display("txn reset_mid_wait: requester 0 granted first after reset");
  endtask

  task automatic test_enable();
    bit stray;
    enable   = 1'b0;
    req      = 4'b0100;
    req_data = 32'h00C7_0000;
    stray    = 1'b0;
    repeat (100) begin
      tick();
      if (gnt !== 4'b0 || byte_en !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL enable_hold: got activity while disabled, want none");
    end
    enable = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_start: got gnt=%b busy=%b, want 0000 1", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || data_byte !== 8'hC7) begin
      errors++;
      $display("FAIL enable_gnt: got gnt=%b data=%h, want 0100 c7", gnt, data_byte);
    end
    req    = 4'b0000;
    enable = 1'b0;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("FAIL enable_drop_done: got %b, want 0100", done);
    end
    enable = 1'b1;
    $display("txn enable: requester 2 granted after enable, completed with enable low");
  endtask

  task automatic test_tx_done_idle();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_tx_done: got done=%b busy=%b tmo=%b, want 0000 0 0", done, busy, timeout_err);
    end
    tick();
    checks++;
    if (done !== 4'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL idle_tx_done_after: got done=%b gnt=%b, want 0000 0000", done, gnt);
    end
    $display("txn idle_tx_done: ignored");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    enable   = 1'b1;
    req      = 4'b0;
    req_data = 32'h0;
    tx_done  = 1'b0;
    repeat (2) tick();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_timeout_race();
    test_reset_mid_wait();
    test_enable();
    test_tx_done_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
